// File: rtl/la_idlefilter3_pkg.sv
// Shared definitions for the idle filter: state encoding of the qualification FSM.
package la_idlefilter3_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_COUNT   = 2'd1,
        ST_IDLE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

endpackage

// File: rtl/la_nor3.sv
// Three-input NOR cell; PROP names an implementation flavour.
module la_nor3 #(
    parameter string PROP = "DEFAULT"
) (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic z
);

    // Only the portable mapping exists; any PROP value resolves to it.
    if (PROP == "DEFAULT") begin : g_default
        assign z = ~(a | b | c);
    end else begin : g_generic
        assign z = ~(a | b | c);
    end

endmodule

// File: rtl/la_idlefilter3.sv
// Idle filter: registers three activity lines, qualifies "all quiet" for a
// programmable number of cycles, then asserts idle with enter/wake pulses.
module la_idlefilter3
    import la_idlefilter3_pkg::*;
#(
    parameter string PROP = "DEFAULT",
    parameter int    CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          a,
    input  logic          b,
    input  logic          c,
    input  logic [CW-1:0] thresh,
    output logic          idle,
    output logic          enter,
    output logic          wake,
    output logic [CW-1:0] count
);

    logic          r_a, r_b, r_c;
    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_enter, r_wake;

    logic          w_quiet;
    logic [CW-1:0] w_teff;
    logic [CW:0]   w_nxt;
    logic [CW-1:0] w_nxt_sat;
    state_t        w_state_nxt;
    logic [CW-1:0] w_count_nxt;
    logic          w_enter_nxt, w_wake_nxt;

    la_nor3 #(.PROP(PROP)) u_nor3 (
        .a (r_a),
        .b (r_b),
        .c (r_c),
        .z (w_quiet)
    );

    assign w_teff    = (thresh == '0) ? CW'(1) : thresh;
    // One extra bit so the threshold compare never sees a wrapped count.
    assign w_nxt     = {1'b0, r_count} + (CW+1)'(1);
    assign w_nxt_sat = w_nxt[CW] ? '1 : w_nxt[CW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_enter_nxt = 1'b0;
        w_wake_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = ST_ACTIVE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (w_quiet) begin
                        w_count_nxt = CW'(1);
                        if (w_teff == CW'(1)) begin
                            w_state_nxt = ST_IDLE;
                            w_enter_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_COUNT;
                        end
                    end else begin
                        w_count_nxt = '0;
                    end
                end
                ST_COUNT: begin
                    if (w_quiet) begin
                        w_count_nxt = w_nxt_sat;
                        if (w_nxt >= {1'b0, w_teff}) begin
                            w_state_nxt = ST_IDLE;
                            w_enter_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                        w_count_nxt = '0;
                    end
                end
                ST_IDLE: begin
                    if (!w_quiet) begin
                        w_state_nxt = ST_ACTIVE;
                        w_count_nxt = '0;
                        w_wake_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACTIVE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_c     <= 1'b0;
            r_state <= ST_ACTIVE;
            r_count <= '0;
            r_enter <= 1'b0;
            r_wake  <= 1'b0;
        end else begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= c;
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_enter <= w_enter_nxt;
            r_wake  <= w_wake_nxt;
        end
    end

    assign idle  = (r_state == ST_IDLE);
    assign enter = r_enter;
    assign wake  = r_wake;
    assign count = r_count;

endmodule

// File: tb/tb_la_idlefilter3.sv
// Directed bench for la_idlefilter3: quiet-run model checked every cycle plus literal checkpoints.
module tb_la_idlefilter3;

    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, en, a, b, c;
    logic [CW-1:0] thresh;
    logic          idle, enter, wake;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // Model: idle flag plus a length of the current quiet run as seen through the input flops.
    bit m_aq, m_bq, m_cq;
    bit m_idle, m_enter, m_wake;
    int m_cnt;

    la_idlefilter3 #(.PROP("DEFAULT"), .CW(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .a      (a),
        .b      (b),
        .c      (c),
        .thresh (thresh),
        .idle   (idle),
        .enter  (enter),
        .wake   (wake),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit quiet;
        int teff;
        if (reset) begin
            m_aq = 0; m_bq = 0; m_cq = 0;
            m_idle = 0; m_enter = 0; m_wake = 0; m_cnt = 0;
        end else begin
            quiet   = !(m_aq || m_bq || m_cq);
            teff    = (thresh == 0) ? 1 : int'(thresh);
            m_enter = 0;
            m_wake  = 0;
            if (!en) begin
                m_idle = 0;
                m_cnt  = 0;
            end else if (m_idle) begin
                if (!quiet) begin
                    m_idle = 0;
                    m_cnt  = 0;
                    m_wake = 1;
                end
            end else if (!quiet) begin
                m_cnt = 0;
            end else begin
                m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
                if (m_cnt >= teff) begin
                    m_idle  = 1;
                    m_enter = 1;
                end
            end
            m_aq = a; m_bq = b; m_cq = c;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_idle",  int'(idle),  int'(m_idle));
            chk("model_enter", int'(enter), int'(m_enter));
            chk("model_wake",  int'(wake),  int'(m_wake));
            chk("model_count", int'(count), m_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect4(input string name, input int ei, input int ee, input int ew, input int ec);
        chk({name, "_idle"},  int'(idle),  ei);
        chk({name, "_enter"}, int'(enter), ee);
        chk({name, "_wake"},  int'(wake),  ew);
        chk({name, "_count"}, int'(count), ec);
    endtask

    initial begin
        reset = 1; en = 0; a = 1; b = 1; c = 1; thresh = 8'd4;
        step(2);
        model_on = 1'b1;
        expect4("reset_busy", 0, 0, 0, 0);
        a = 0; b = 0; c = 0;
        step(1);
        expect4("reset_quiet", 0, 0, 0, 0);

        // Reset release with quiet inputs: count restarts from 1
        reset = 0; en = 1;
        step(1);  expect4("entry_c1", 0, 0, 0, 1);
        step(2);  expect4("entry_c3", 0, 0, 0, 3);
        step(1);  expect4("entry_idle", 1, 1, 0, 4);
        step(1);  expect4("entry_hold", 1, 0, 0, 4);

        // Wake
        c = 1;
        step(1);  expect4("wake_pre", 1, 0, 0, 4);
        step(1);  expect4("wake_pulse", 0, 0, 1, 0);
        c = 0;
        step(1);  expect4("wake_done", 0, 0, 0, 0);

        // Glitch restarts qualification
        step(2);  expect4("glitch_c2", 0, 0, 0, 2);
        b = 1;
        step(1);  expect4("glitch_c3", 0, 0, 0, 3);
        b = 0;
        step(1);  expect4("glitch_clr", 0, 0, 0, 0);
        step(3);  expect4("glitch_c3b", 0, 0, 0, 3);
        step(1);  expect4("glitch_idle", 1, 1, 0, 4);

        // thresh=0 behaves as 1
        a = 1;
        step(2);  expect4("t0_wake", 0, 0, 1, 0);
        a = 0;
        step(1);  expect4("t0_clr", 0, 0, 0, 0);
        thresh = 8'd0;
        step(1);  expect4("t0_idle", 1, 1, 0, 1);
        thresh = 8'd200;
        step(1);  expect4("idle_thresh_ign", 1, 0, 0, 1);

        // en low in IDLE: silent exit; en release counts from 1
        en = 0;
        step(1);  expect4("en_off", 0, 0, 0, 0);
        en = 1;
        step(1);  expect4("en_on", 0, 0, 0, 1);
        thresh = 8'd10;
        step(4);  expect4("lower_c5", 0, 0, 0, 5);
        thresh = 8'd3;
        step(1);  expect4("lower_idle", 1, 1, 0, 6);

        // Reset at count=3
        a = 1;
        step(2);  expect4("rst_wake", 0, 0, 1, 0);
        a = 0;
        step(1);
        thresh = 8'd10;
        step(3);  expect4("rst_c3", 0, 0, 0, 3);
        reset = 1;
        step(1);  expect4("rst_mid", 0, 0, 0, 0);
        reset = 0;
        step(1);  expect4("rst_rel", 0, 0, 0, 1);

        // Full-width threshold: exactly 255 quiet cycles, no wrap
        thresh = 8'd255;
        a = 1;
        step(1);  expect4("t255_pre", 0, 0, 0, 2);
        step(1);  expect4("t255_clr", 0, 0, 0, 0);
        a = 0;
        step(1);  expect4("t255_clr2", 0, 0, 0, 0);
        step(254); expect4("t255_c254", 0, 0, 0, 254);
        step(1);  expect4("t255_idle", 1, 1, 0, 255);
        step(5);  expect4("t255_hold", 1, 0, 0, 255);

        step(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
